alu_cmd_driver: RTL and testbench

ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

---
 rtl/alu_cmd_driver.sv | 150 +++++++++++++++
 tb/tb_alu_cmd_driver.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// Sequences one command at a time onto an external ALU and returns a single response with status.
// Legal ops answer after ISSUE plus up to TIMEOUT WAIT cycles, illegal ops answer directly; response is held until rsp_ready.
module alu_cmd_driver #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [15:0] TXN_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic        alu_ready,
  input  logic [31:0] alu_out,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_out,
  output logic        rsp_carry,
  output logic [2:0]  rsp_op,
  output logic [1:0]  rsp_status,
  output logic [15:0] txn_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] OP_NONE    = 3'b000;
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ILLEGAL = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  wait_cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        accept;
  logic        take_result;
  logic        take_timeout;
  logic        rsp_done;
  logic        cnt_clr;
  logic        cnt_inc;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    take_result  = 1'b0;
    take_timeout = 1'b0;
    rsp_done     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = (cmd_op == OP_NONE) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        // alu_ready is deliberately ignored here; counting starts on WAIT entry
        cnt_clr = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (alu_ready) begin
          take_result = 1'b1;
          state_d     = RESP;
        end else if (wait_cnt == WAIT_LAST) begin
          take_timeout = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      op_q       <= OP_NONE;
      a_q        <= '0;
      b_q        <= '0;
      wait_cnt   <= '0;
      rsp_out    <= '0;
      rsp_carry  <= 1'b0;
      rsp_status <= ST_OK;
      txn_count  <= TXN_INIT;
    end else begin
      if (accept) begin
        op_q <= cmd_op;
        // illegal commands never reach the ALU, so its operand bus keeps its old value
        if (cmd_op == OP_NONE) begin
          rsp_out    <= '0;
          rsp_carry  <= 1'b0;
          rsp_status <= ST_ILLEGAL;
        end else begin
          a_q <= cmd_a;
          b_q <= cmd_b;
        end
      end
      if (cnt_clr) begin
        wait_cnt <= '0;
      end else if (cnt_inc) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (take_result) begin
        rsp_out    <= alu_out;
        rsp_carry  <= alu_carry;
        rsp_status <= ST_OK;
      end
      if (take_timeout) begin
        rsp_out    <= '0;
        rsp_carry  <= 1'b0;
        rsp_status <= ST_TIMEOUT;
      end
      if (rsp_done) begin
        txn_count <= txn_count + 16'd1;
      end
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign alu_op    = (state_q == ISSUE || state_q == WAIT) ? op_q : OP_NONE;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_op    = op_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Randomised and directed bench for alu_cmd_driver with a behavioural ALU and a per-cycle expectation model.
module tb_alu_cmd_driver;
  localparam int          TIMEOUT  = 16;
  localparam logic [15:0] TXN_INIT = 16'hFFF8;

  logic        clk = 1'b0;
  logic        nrst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [2:0]  cmd_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_ready;
  logic [31:0] alu_out;
  logic        alu_carry;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_out;
  logic        rsp_carry;
  logic [2:0]  rsp_op;
  logic [1:0]  rsp_status;
  logic [15:0] txn_count;

  alu_cmd_driver #(.TIMEOUT(TIMEOUT), .TXN_INIT(TXN_INIT)) dut (
    .clk(clk), .nrst(nrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_ready(alu_ready), .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_carry(rsp_carry), .rsp_op(rsp_op), .rsp_status(rsp_status),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  // Reference ALU: {carry, result}; opcode 000 yields a poison value to catch stray captures
  function automatic logic [32:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b001:  return {1'b0, a} + {1'b0, b};
      3'b010:  return {1'b0, a} - {1'b0, b};
      3'b011:  return {1'b0, a * b};
      3'b100:  return {1'b0, a ^ b};
      3'b101:  return {1'b0, a & b};
      3'b110:  return {1'b0, a | b};
      3'b111:  return {1'b0, ~a};
      default: return {1'b1, 32'hDEAD_BEEF};
    endcase
  endfunction

  assign {alu_carry, alu_out} = alu_model(alu_op, alu_a, alu_b);

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  logic        exp_cmd_ready;
  logic        exp_rsp_valid;
  logic [2:0]  exp_alu_op;
  logic [31:0] exp_alu_a;
  logic [31:0] exp_alu_b;
  logic [31:0] exp_rsp_out;
  logic        exp_rsp_carry;
  logic [2:0]  exp_rsp_op;
  logic [1:0]  exp_rsp_status;
  logic [15:0] exp_txn;

  int          k;
  int          obs_lat;
  int          alu_cyc;
  logic [31:0] obs_out;
  logic        obs_carry;
  logic [1:0]  obs_status;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_cmd_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
      chk("alu_op", 32'(alu_op), 32'(exp_alu_op));
      chk("alu_a", alu_a, exp_alu_a);
      chk("alu_b", alu_b, exp_alu_b);
      chk("txn_count", 32'(txn_count), 32'(exp_txn));
      if (exp_rsp_valid) begin
        chk("rsp_out", rsp_out, exp_rsp_out);
        chk("rsp_carry", 32'(rsp_carry), 32'(exp_rsp_carry));
        chk("rsp_op", 32'(rsp_op), 32'(exp_rsp_op));
        chk("rsp_status", 32'(rsp_status), 32'(exp_rsp_status));
      end
    end
  end

  task automatic set_idle();
    exp_cmd_ready = 1'b1;
    exp_rsp_valid = 1'b0;
    exp_alu_op    = 3'b000;
  endtask

  task automatic step();
    @(negedge clk);
    if (alu_op !== 3'b000) alu_cyc++;
    if (rsp_valid === 1'b1 && obs_lat < 0) begin
      obs_lat    = k;
      obs_out    = rsp_out;
      obs_carry  = rsp_carry;
      obs_status = rsp_status;
    end
    @(posedge clk);
    #1;
  endtask

  // dly: WAIT cycles with alu_ready low before it rises (>= TIMEOUT means never); hold: rsp_ready low cycles
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input int dly, input int hold);
    logic [32:0] r;
    logic [31:0] o;
    logic        c;
    logic [1:0]  st;
    int          w;
    r = alu_model(op, a, b);
    if (op == 3'b000) begin
      st = 2'b01; o = '0; c = 1'b0; w = 0;
    end else if (dly < TIMEOUT) begin
      st = 2'b00; o = r[31:0]; c = r[32]; w = dly + 1;
    end else begin
      st = 2'b10; o = '0; c = 1'b0; w = TIMEOUT;
    end
    obs_lat = -1;
    alu_cyc = 0;
    set_idle();
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    rsp_ready = 1'($urandom_range(0, 1));
    alu_ready = 1'($urandom_range(0, 1));
    step();
    k = 0;
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_a = $urandom; cmd_b = $urandom; cmd_op = 3'($urandom_range(0, 7));
    exp_cmd_ready = 1'b0;
    if (op != 3'b000) begin
      exp_alu_a = a; exp_alu_b = b; exp_alu_op = op;
      alu_ready = 1'($urandom_range(0, 1));
      step(); k++;
      for (int i = 0; i < w; i++) begin
        alu_ready = (i == dly);
        step(); k++;
      end
    end
    exp_alu_op = 3'b000; exp_rsp_valid = 1'b1;
    exp_rsp_out = o; exp_rsp_carry = c; exp_rsp_op = op; exp_rsp_status = st;
    for (int i = 0; i <= hold; i++) begin
      rsp_ready = (i == hold);
      cmd_valid = (i != hold);
      cmd_a = $urandom; cmd_b = $urandom; cmd_op = 3'($urandom_range(0, 7));
      alu_ready = 1'($urandom_range(0, 1));
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    exp_txn = exp_txn + 16'd1;
    set_idle();
  endtask

  initial begin
    nrst = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = 3'b000;
    alu_ready = 1'b0; rsp_ready = 1'b0;
    exp_alu_a = '0; exp_alu_b = '0; exp_txn = TXN_INIT;
    exp_rsp_out = '0; exp_rsp_carry = 1'b0; exp_rsp_op = 3'b000; exp_rsp_status = 2'b00;
    k = 0; obs_lat = -1; alu_cyc = 0; obs_out = '0; obs_carry = 1'b0; obs_status = 2'b00;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_rsp_out", rsp_out, 32'd0);
    chk("rst_txn", 32'(txn_count), 32'(TXN_INIT));
    nrst = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    run_txn(32'd5, 32'd7, 3'b001, 0, 0);
    chk("add_out", obs_out, 32'd12);
    chk("add_carry", 32'(obs_carry), 32'd0);
    chk("add_status", 32'(obs_status), 32'd0);
    chk("add_latency", 32'(obs_lat), 32'd2);
    chk("add_txn", 32'(txn_count), 32'h0000_FFF9);

    run_txn(32'd0, 32'd1, 3'b010, 0, 1);
    chk("sub_out", obs_out, 32'hFFFF_FFFF);
    chk("sub_carry", 32'(obs_carry), 32'd1);
    chk("sub_alu_cycles", 32'(alu_cyc), 32'd2);

    run_txn(32'h1234_5678, 32'h9ABC_DEF0, 3'b000, 0, 0);
    chk("ill_latency", 32'(obs_lat), 32'd0);
    chk("ill_status", 32'(obs_status), 32'd1);
    chk("ill_out", obs_out, 32'd0);
    chk("ill_alu_cycles", 32'(alu_cyc), 32'd0);

    run_txn(32'd3, 32'd4, 3'b011, 5, 0);
    chk("mul_out", obs_out, 32'd12);
    chk("mul_latency", 32'(obs_lat), 32'd7);

    run_txn(32'd3, 32'd4, 3'b011, TIMEOUT, 0);
    chk("to_status", 32'(obs_status), 32'd2);
    chk("to_out", obs_out, 32'd0);
    chk("to_alu_cycles", 32'(alu_cyc), 32'd17);

    run_txn(32'd3, 32'd4, 3'b011, TIMEOUT - 1, 0);
    chk("last_wait_status", 32'(obs_status), 32'd0);
    chk("last_wait_out", obs_out, 32'd12);

    run_txn(32'hF0F0_0000, 32'h0FF0_FFFF, 3'b100, 0, 10);
    chk("bp_out", obs_out, 32'hFF00_FFFF);
    chk("bp_txn", 32'(txn_count), 32'h0000_FFFF);

    run_txn(32'hFFFF_FFFF, 32'd1, 3'b001, 2, 0);
    chk("wrap_carry", 32'(obs_carry), 32'd1);
    chk("wrap_txn", 32'(txn_count), 32'd0);

    for (int t = 0; t < 40; t++) begin
      logic [2:0] op;
      int         dly;
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       dly = 0;
        1:       dly = int'($urandom_range(1, TIMEOUT - 1));
        2:       dly = TIMEOUT + int'($urandom_range(0, 3));
        default: dly = int'($urandom_range(0, 3));
      endcase
      run_txn($urandom, $urandom, op, dly, int'($urandom_range(0, 3)));
    end

    // reset pulse while the ALU is being waited on
    set_idle();
    cmd_valid = 1'b1; cmd_a = 32'd100; cmd_b = 32'd23; cmd_op = 3'b001; alu_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    exp_cmd_ready = 1'b0; exp_alu_a = 32'd100; exp_alu_b = 32'd23; exp_alu_op = 3'b001;
    step();
    step();
    chk_en = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_alu_op", 32'(alu_op), 32'd0);
    chk("arst_alu_a", alu_a, 32'd0);
    chk("arst_alu_b", alu_b, 32'd0);
    chk("arst_rsp_out", rsp_out, 32'd0);
    chk("arst_rsp_carry", 32'(rsp_carry), 32'd0);
    chk("arst_rsp_op", 32'(rsp_op), 32'd0);
    chk("arst_rsp_status", 32'(rsp_status), 32'd0);
    chk("arst_txn", 32'(txn_count), 32'(TXN_INIT));
    @(posedge clk);
    #1;
    nrst = 1'b1;
    exp_alu_a = '0; exp_alu_b = '0; exp_txn = TXN_INIT;
    set_idle();
    alu_ready = 1'b1; rsp_ready = 1'b1;
    chk_en = 1'b1;
    repeat (4) step();
    rsp_ready = 1'b0;
    run_txn(32'd40, 32'd2, 3'b010, 1, 0);
    chk("post_rst_out", obs_out, 32'd38);
    chk("post_rst_txn", 32'(txn_count), 32'h0000_FFF9);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
